// File: rtl/mem_arbiter.sv
// Shares the single-port SOC RAM between instruction fetch (port 0) and the load/store
// unit (port 1); each port gets one-cycle done pulses, peak rate one transaction per 2 cycles.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [31:0]           m0_wdata,
   input  logic [3:0]            m0_wmask,
   input  logic                  m0_rstrb,
   output logic [31:0]           m0_rdata,
   output logic                  m0_done,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [31:0]           m1_wdata,
   input  logic [3:0]            m1_wmask,
   input  logic                  m1_rstrb,
   output logic [31:0]           m1_rdata,
   output logic                  m1_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_rstrb,
   input  logic [31:0]           mem_rdata,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] in_addr   [2];
   logic [31:0]           in_wdata  [2];
   logic [3:0]            in_wmask  [2];
   logic [ADDR_WIDTH-1:0] addr_q    [2];
   logic [31:0]           wdata_q   [2];
   logic [3:0]            wmask_q   [2];
   logic [ADDR_WIDTH-1:0] sel_addr  [2];
   logic [31:0]           sel_wdata [2];
   logic [3:0]            sel_wmask [2];
   logic [31:0]           rdata_q   [2];
   logic [1:0]            req, in_flight, drop, accept, pend, pend_eff, done_q;
   logic                  last, gnt, cur_write, grant_ok, grant_port;

   assign in_addr[0]  = m0_addr;
   assign in_addr[1]  = m1_addr;
   assign in_wdata[0] = m0_wdata;
   assign in_wdata[1] = m1_wdata;
   assign in_wmask[0] = m0_wmask;
   assign in_wmask[1] = m1_wmask;
   assign req         = {(m1_wmask != 4'b0) || m1_rstrb, (m0_wmask != 4'b0) || m0_rstrb};

   assign m0_rdata = rdata_q[0];
   assign m1_rdata = rdata_q[1];
   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];

   // A request captured this edge may be granted this edge, so grant data bypasses the latch
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         in_flight[k] = (state != IDLE) && (gnt == 1'(k));
         drop[k]      = req[k] && (pend[k] || in_flight[k]);
         accept[k]    = req[k] && !drop[k];
         sel_addr[k]  = accept[k] ? in_addr[k]  : addr_q[k];
         sel_wdata[k] = accept[k] ? in_wdata[k] : wdata_q[k];
         sel_wmask[k] = accept[k] ? in_wmask[k] : wmask_q[k];
      end
      pend_eff = pend | accept;
   end

   always_comb begin
      state_next = state;
      grant_ok   = 1'b0;
      grant_port = 1'b0;
      if ((state == IDLE || state == RESP) && pend_eff != 2'b00) begin
         grant_ok = 1'b1;
         if (pend_eff == 2'b11) begin
            grant_port = FIXED_PRIO ? 1'b1 : ~last;
         end else begin
            grant_port = pend_eff[1];
         end
      end
      case (state)
         IDLE:    if (grant_ok) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    state_next = grant_ok ? ISSUE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= 2'b00;
         last      <= 1'b1;
         gnt       <= 1'b0;
         cur_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         done_q    <= 2'b00;
         err       <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            rdata_q[k] <= '0;
            addr_q[k]  <= '0;
            wdata_q[k] <= '0;
            wmask_q[k] <= '0;
         end
      end else begin
         state     <= state_next;
         err       <= err | (drop != 2'b00);
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         done_q    <= 2'b00;
         for (int k = 0; k < 2; k++) begin
            if (accept[k]) begin
               pend[k]    <= 1'b1;
               addr_q[k]  <= in_addr[k];
               wdata_q[k] <= in_wdata[k];
               wmask_q[k] <= in_wmask[k];
            end
         end
         // Completing the current transaction; the RAM read data is valid during RESP
         if (state == RESP) begin
            done_q[gnt] <= 1'b1;
            if (!cur_write) rdata_q[gnt] <= mem_rdata;
         end
         if (grant_ok) begin
            pend[grant_port] <= 1'b0;
            gnt              <= grant_port;
            last             <= grant_port;
            mem_addr         <= sel_addr[grant_port];
            mem_wdata        <= sel_wdata[grant_port];
            cur_write        <= (sel_wmask[grant_port] != 4'b0);
            if (sel_wmask[grant_port] != 4'b0) begin
               mem_wmask <= sel_wmask[grant_port];
            end else begin
               mem_rstrb <= 1'b1;
            end
         end
      end
   end

endmodule
